// File: rtl/keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_pkg
//  Brief    : Shared state encodings, key codes and column helpers for the
//             vending-machine keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Key codes are {row_idx, col_idx}; these name the dedicated coin/aisle keys.
    localparam logic [3:0] KEY_COIN_5   = 4'h3;
    localparam logic [3:0] KEY_COIN_10  = 4'h7;
    localparam logic [3:0] KEY_CANCEL   = 4'hB;
    localparam logic [3:0] KEY_ENTER    = 4'hF;
    localparam logic [3:0] KEY_AISLE_A  = 4'hC;
    localparam logic [3:0] KEY_AISLE_B  = 4'hD;

    // Exactly one active-low column asserted.
    function automatic logic single_zero(input logic [3:0] cols);
        logic [3:0] w_low;
        w_low = ~cols;
        return (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] zero_index(input logic [3:0] cols);
        logic [1:0] w_idx;
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) w_idx = 2'(i);
        end
        return w_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Two-flop synchroniser, resets to all ones (idle pulled-up level).
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Brief    : 4x4 matrix keypad scanner with tick-based debounce; one key_valid
//             pulse per accepted press, key_held until release is debounced.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);
    localparam logic             SINGLE   = (DEBOUNCE_TICKS == 1);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [3:0]       w_col_s;

    state_t           r_state,    w_state_nxt;
    logic [1:0]       r_row_idx,  w_row_idx_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [3:0]       r_latched,  w_latched_nxt;
    logic [3:0]       r_key_code, w_key_code_nxt;
    logic             r_valid,    w_valid_nxt;
    logic             r_held,     w_held_nxt;
    logic [3:0]       r_row;

    sync_2ff #(.WIDTH(4)) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (w_col_s)
    );

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= 2'd0;
            r_cnt      <= '0;
            r_latched  <= 4'hF;
            r_key_code <= 4'd0;
            r_valid    <= 1'b0;
            r_held     <= 1'b0;
            r_row      <= 4'b1110;
        end else begin
            r_state    <= w_state_nxt;
            r_row_idx  <= w_row_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_latched  <= w_latched_nxt;
            r_key_code <= w_key_code_nxt;
            r_valid    <= w_valid_nxt;
            r_held     <= w_held_nxt;
            r_row      <= ~(4'b0001 << w_row_idx_nxt);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_row_idx_nxt  = r_row_idx;
        w_cnt_nxt      = r_cnt;
        w_latched_nxt  = r_latched;
        w_key_code_nxt = r_key_code;
        w_valid_nxt    = 1'b0;
        w_held_nxt     = r_held;

        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (single_zero(w_col_s)) begin
                        w_latched_nxt = w_col_s;
                        if (SINGLE) begin
                            w_state_nxt    = ST_PRESSED;
                            w_key_code_nxt = {r_row_idx, zero_index(w_col_s)};
                            w_valid_nxt    = 1'b1;
                            w_held_nxt     = 1'b1;
                            w_cnt_nxt      = '0;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        // Idle row or ghosted multi-key: move on either way.
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_col_s == r_latched) begin
                        if (r_cnt + CNT_ONE == CNT_DONE) begin
                            w_state_nxt    = ST_PRESSED;
                            w_key_code_nxt = {r_row_idx, zero_index(r_latched)};
                            w_valid_nxt    = 1'b1;
                            w_held_nxt     = 1'b1;
                            w_cnt_nxt      = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_cnt_nxt   = '0;
                    end
                end

                ST_PRESSED: begin
                    if (w_col_s == 4'hF) begin
                        if (SINGLE) begin
                            w_state_nxt   = ST_SCAN;
                            w_held_nxt    = 1'b0;
                            w_row_idx_nxt = r_row_idx + 2'd1;
                            w_cnt_nxt     = '0;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (w_col_s == 4'hF) begin
                        if (r_cnt + CNT_ONE == CNT_DONE) begin
                            w_state_nxt   = ST_SCAN;
                            w_held_nxt    = 1'b0;
                            w_row_idx_nxt = r_row_idx + 2'd1;
                            w_cnt_nxt     = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end else begin
                        // Bounce back to held without a fresh key_valid.
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end

                default: begin
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign row       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan
//  Brief    : Directed self-checking bench for keypad_scan with a matrix model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] mask [4];   // mask[r][c] = 1 means key (r,c) is pressed

    int         n_tests;
    int         n_fail;
    int         pulses;
    logic [3:0] last_code;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } press_t;

    press_t tbl [5];

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        logic [3:0] w_col;
        w_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) w_col = w_col & ~mask[r];
        end
        col = w_col;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (key_valid === 1'b1) begin
            pulses++;
            last_code = key_code;
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) mask[r] = 4'h0;
    endtask

    task automatic wait_release(input string name);
        for (int k = 0; k < 40 && key_held; k++) step();
        check(name, {31'd0, key_held}, 32'd0);
    endtask

    initial begin
        int         held_drop;
        logic [3:0] seen;
        logic [3:0] exp_row;

        n_tests = 0;
        n_fail  = 0;
        pulses  = 0;
        last_code = 4'h0;
        clear_keys();

        tbl[0] = '{2, 1, 4'h9};
        tbl[1] = '{0, 0, 4'h0};
        tbl[2] = '{3, 3, 4'hF};
        tbl[3] = '{1, 2, 4'h6};
        tbl[4] = '{0, 3, 4'h3};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row",   {28'd0, row},      32'hE);
        check("rst_code",  {28'd0, key_code}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held",  {31'd0, key_held},  32'd0);
        rst = 1'b0;

        // Idle scan: each row dwells 4 clk, wrapping back to row 0
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check("idle_row", {28'd0, row}, {28'd0, exp_row});
        end
        check("idle_no_valid", pulses, 0);

        // Table of clean presses
        for (int i = 0; i < 5; i++) begin
            pulses    = 0;
            held_drop = 0;
            mask[tbl[i].r] = 4'b0001 << tbl[i].c;
            for (int k = 0; k < 60; k++) begin
                step();
                if (pulses > 0 && !key_held) held_drop = 1;
            end
            check("press_pulses", pulses, 1);
            check("press_code", {28'd0, last_code}, {28'd0, tbl[i].code});
            check("press_held", {31'd0, key_held}, 32'd1);
            check("press_held_steady", held_drop, 0);
            clear_keys();
            wait_release("press_release");
            repeat (8) step();
            check("press_code_kept", {28'd0, key_code}, {28'd0, tbl[i].code});
            check("press_no_repeat", pulses, 1);
        end

        // Contact bounce on key (1,2): nothing until it settles
        pulses = 0;
        for (int ph = 0; ph < 6; ph++) begin
            mask[1] = (ph % 2 == 0) ? 4'b0100 : 4'b0000;
            repeat (5) step();
        end
        check("bounce_quiet", pulses, 0);
        mask[1] = 4'b0100;
        repeat (60) step();
        check("bounce_pulses", pulses, 1);
        check("bounce_code", {28'd0, last_code}, 32'h6);
        clear_keys();
        wait_release("bounce_release");

        // Ghost: two columns on row 0
        pulses = 0;
        seen   = 4'h0;
        mask[0] = 4'b0011;
        for (int k = 0; k < 40; k++) begin
            step();
            seen = seen | ~row;
        end
        check("ghost_no_valid", pulses, 0);
        check("ghost_rows_advance", {28'd0, seen}, 32'hF);
        check("ghost_not_held", {31'd0, key_held}, 32'd0);
        clear_keys();
        repeat (8) step();

        // Release bounce: brief release then re-press keeps key held
        pulses    = 0;
        held_drop = 0;
        mask[2] = 4'b0010;
        for (int k = 0; k < 60 && pulses == 0; k++) step();
        check("rb_first_pulse", pulses, 1);
        repeat (8) step();
        mask[2] = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            if (!key_held) held_drop = 1;
        end
        mask[2] = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!key_held) held_drop = 1;
        end
        check("rb_held_through", held_drop, 0);
        clear_keys();
        wait_release("rb_release");
        check("rb_single_pulse", pulses, 1);
        check("rb_code", {28'd0, key_code}, 32'h9);

        // Reset while a key is held down
        pulses = 0;
        mask[3] = 4'b0001;
        for (int k = 0; k < 60 && pulses == 0; k++) step();
        check("rp_first_pulse", pulses, 1);
        repeat (5) step();
        check("rp_held_before", {31'd0, key_held}, 32'd1);
        rst = 1'b1;
        #1;
        check("rp_row",   {28'd0, row},       32'hE);
        check("rp_code",  {28'd0, key_code},  32'h0);
        check("rp_valid", {31'd0, key_valid}, 32'd0);
        check("rp_held",  {31'd0, key_held},  32'd0);
        repeat (2) step();
        rst    = 1'b0;
        pulses = 0;
        repeat (80) step();
        check("rp_redetect_pulses", pulses, 1);
        check("rp_redetect_code", {28'd0, last_code}, 32'hC);
        clear_keys();
        wait_release("rp_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
